// File: rtl/conv_pkg.sv
// Shared types and constants for the FFT convolution sequencer.
// Buffer-select encodings must match the datapath muxes around fft_controller.
package conv_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_K_START,
      ST_K_WAIT,
      ST_S_START,
      ST_S_WAIT,
      ST_MUL,
      ST_I_START,
      ST_I_WAIT,
      ST_DONE,
      ST_ERR
   } conv_state_t;

   localparam logic [1:0] SRC_KERNEL  = 2'd0;
   localparam logic [1:0] SRC_SIGNAL  = 2'd1;
   localparam logic [1:0] SRC_PRODUCT = 2'd2;

   localparam logic [1:0] DST_KERNEL_SPEC = 2'd0;
   localparam logic [1:0] DST_SIGNAL_SPEC = 2'd1;
   localparam logic [1:0] DST_TIME_OUT    = 2'd2;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT   = 2'd1;
   localparam logic [1:0] ERR_NO_KERNEL = 2'd2;
   localparam logic [1:0] ERR_OVERRUN   = 2'd3;

   function automatic logic is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

   // States in which the watchdog runs
   function automatic logic is_wait_state(input conv_state_t s);
      return s inside {ST_K_WAIT, ST_S_WAIT, ST_I_WAIT, ST_MUL};
   endfunction

   function automatic logic is_fft_wait(input conv_state_t s);
      return s inside {ST_K_WAIT, ST_S_WAIT, ST_I_WAIT};
   endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle counter for the sequencer's wait states; flags the cycle on which
// the count reaches TIMEOUT_CYCLES.
module seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] ONE   = TW'(1);

   logic [TW-1:0] count_q, count_d;

   // Saturate at the limit so a stalled FSM can never wrap the counter
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != LIMIT)) begin
         count_d = count_q + ONE;
      end
   end

   assign expired_o = enable_i && ((count_q + ONE) == LIMIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/conv_sequencer.sv
// Schedules kernel FFT, then per block forward FFT -> spectral multiply -> inverse FFT
// on one shared fft_controller. Controls only; no sample data passes through here.
module conv_sequencer
   import conv_pkg::*;
#(
   parameter int FFT_POINTS     = 16,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       kernel_load,
   input  logic       block_start,
   input  logic       fft_in_prog,
   input  logic       fft_data_valid,
   input  logic       mul_done,
   input  logic       err_clear,
   output logic       fft_start,
   output logic       fft_forward,
   output logic [1:0] fft_src_sel,
   output logic [1:0] fft_dst_sel,
   output logic       fft_capture,
   output logic       mul_start,
   output logic       block_done,
   output logic       kernel_ready,
   output logic       busy,
   output logic [1:0] err_code
);

   if (!is_pow2(FFT_POINTS)) begin : g_bad_points
      $error("conv_sequencer: FFT_POINTS must be a power of two");
   end

   conv_state_t state_q, state_d;
   logic        armed_q, armed_d;
   logic        pend_k_q, pend_k_d;
   logic        pend_b_q, pend_b_d;
   logic [1:0]  err_code_q, err_code_d;
   logic        kernel_ready_q, kernel_ready_d;
   logic        fft_start_q, fft_start_d;
   logic        fft_forward_q, fft_forward_d;
   logic [1:0]  src_q, src_d;
   logic [1:0]  dst_q, dst_d;
   logic        fft_capture_q, fft_capture_d;
   logic        mul_start_q, mul_start_d;
   logic        block_done_q, block_done_d;
   logic        busy_q, busy_d;

   logic fft_done;
   logic wd_expired;
   logic timeout;

   // A stale fft_data_valid from the previous transform must not complete a wait,
   // so completion requires having seen the controller busy first.
   assign fft_done = is_fft_wait(state_q) && armed_q && fft_data_valid && !fft_in_prog;
   assign timeout  = wd_expired && !fft_done && !((state_q == ST_MUL) && mul_done);

   seq_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TW            (TW)
   ) u_watchdog (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_i  (state_d != state_q),
      .enable_i (is_wait_state(state_q)),
      .expired_o(wd_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         armed_q        <= 1'b0;
         pend_k_q       <= 1'b0;
         pend_b_q       <= 1'b0;
         err_code_q     <= ERR_NONE;
         kernel_ready_q <= 1'b0;
         fft_start_q    <= 1'b0;
         fft_forward_q  <= 1'b1;
         src_q          <= SRC_KERNEL;
         dst_q          <= DST_KERNEL_SPEC;
         fft_capture_q  <= 1'b0;
         mul_start_q    <= 1'b0;
         block_done_q   <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         armed_q        <= armed_d;
         pend_k_q       <= pend_k_d;
         pend_b_q       <= pend_b_d;
         err_code_q     <= err_code_d;
         kernel_ready_q <= kernel_ready_d;
         fft_start_q    <= fft_start_d;
         fft_forward_q  <= fft_forward_d;
         src_q          <= src_d;
         dst_q          <= dst_d;
         fft_capture_q  <= fft_capture_d;
         mul_start_q    <= mul_start_d;
         block_done_q   <= block_done_d;
         busy_q         <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (kernel_load || pend_k_q) begin
               state_d = ST_K_START;
            end else if ((block_start || pend_b_q) && kernel_ready_q) begin
               state_d = ST_S_START;
            end
         end
         ST_K_START: state_d = ST_K_WAIT;
         ST_S_START: state_d = ST_S_WAIT;
         ST_I_START: state_d = ST_I_WAIT;
         ST_K_WAIT: begin
            if (fft_done)     state_d = ST_IDLE;
            else if (timeout) state_d = ST_ERR;
         end
         ST_S_WAIT: begin
            if (fft_done)     state_d = ST_MUL;
            else if (timeout) state_d = ST_ERR;
         end
         ST_I_WAIT: begin
            if (fft_done)     state_d = ST_DONE;
            else if (timeout) state_d = ST_ERR;
         end
         ST_MUL: begin
            if (mul_done)     state_d = ST_I_START;
            else if (timeout) state_d = ST_ERR;
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR: begin
            if (err_clear) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state so every strobe lines up with its transition
   always_comb begin
      pend_k_d       = pend_k_q;
      pend_b_d       = pend_b_q;
      err_code_d     = err_clear ? ERR_NONE : err_code_q;
      kernel_ready_d = kernel_ready_q;
      armed_d        = is_fft_wait(state_q) && (armed_q || fft_in_prog);
      fft_start_d    = 1'b0;
      fft_forward_d  = fft_forward_q;
      src_d          = src_q;
      dst_d          = dst_q;
      fft_capture_d  = fft_done;
      mul_start_d    = 1'b0;
      block_done_d   = 1'b0;
      busy_d         = (state_d != ST_IDLE);

      if (state_q == ST_IDLE) begin
         if (kernel_load || pend_k_q) begin
            pend_k_d = 1'b0;
            if (block_start) begin
               if (pend_b_q) err_code_d = ERR_OVERRUN;
               else          pend_b_d   = 1'b1;
            end
         end else if (block_start || pend_b_q) begin
            pend_b_d = kernel_ready_q && pend_b_q && block_start;
            if (!kernel_ready_q) err_code_d = ERR_NO_KERNEL;
         end
      end else if (state_q != ST_ERR) begin
         if (kernel_load) pend_k_d = 1'b1;
         if (block_start) begin
            if (pend_b_q) err_code_d = ERR_OVERRUN;
            else          pend_b_d   = 1'b1;
         end
      end

      if ((state_q == ST_K_WAIT) && fft_done) kernel_ready_d = 1'b1;

      if (timeout) begin
         pend_k_d   = 1'b0;
         pend_b_d   = 1'b0;
         err_code_d = ERR_TIMEOUT;
      end

      case (state_d)
         ST_K_START: begin
            fft_start_d    = 1'b1;
            fft_forward_d  = 1'b1;
            src_d          = SRC_KERNEL;
            dst_d          = DST_KERNEL_SPEC;
            kernel_ready_d = 1'b0;
         end
         ST_S_START: begin
            fft_start_d   = 1'b1;
            fft_forward_d = 1'b1;
            src_d         = SRC_SIGNAL;
            dst_d         = DST_SIGNAL_SPEC;
         end
         ST_I_START: begin
            fft_start_d   = 1'b1;
            fft_forward_d = 1'b0;
            src_d         = SRC_PRODUCT;
            dst_d         = DST_TIME_OUT;
         end
         ST_MUL:  mul_start_d  = (state_q != ST_MUL);
         ST_DONE: block_done_d = 1'b1;
         default: ;
      endcase
   end

   assign fft_start    = fft_start_q;
   assign fft_forward  = fft_forward_q;
   assign fft_src_sel  = src_q;
   assign fft_dst_sel  = dst_q;
   assign fft_capture  = fft_capture_q;
   assign mul_start    = mul_start_q;
   assign block_done   = block_done_q;
   assign kernel_ready = kernel_ready_q;
   assign busy         = busy_q;
   assign err_code     = err_code_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: behavioural fft_controller and multiplier models,
// a table of request vectors, then hand-written multi-cycle corner cases.
module tb_conv_sequencer;

   localparam int TimeoutCycles = 64;
   localparam int FftBusyCycles = 20;
   localparam int MulCycles     = 10;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       kernel_load, block_start, err_clear, mul_done;
   logic       fft_in_prog, fft_data_valid;
   logic       fft_start, fft_forward, fft_capture, mul_start, block_done;
   logic       kernel_ready, busy;
   logic [1:0] fft_src_sel, fft_dst_sel, err_code;

   conv_sequencer #(
      .FFT_POINTS    (16),
      .TIMEOUT_CYCLES(TimeoutCycles)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .kernel_load   (kernel_load),
      .block_start   (block_start),
      .fft_in_prog   (fft_in_prog),
      .fft_data_valid(fft_data_valid),
      .mul_done      (mul_done),
      .err_clear     (err_clear),
      .fft_start     (fft_start),
      .fft_forward   (fft_forward),
      .fft_src_sel   (fft_src_sel),
      .fft_dst_sel   (fft_dst_sel),
      .fft_capture   (fft_capture),
      .mul_start     (mul_start),
      .block_done    (block_done),
      .kernel_ready  (kernel_ready),
      .busy          (busy),
      .err_code      (err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       kl;
      logic       bs;
      logic       ec;
      int         expStarts;
      int         expDones;
      logic       expKr;
      logic [1:0] expErr;
   } vecT;

   int         totalChecks  = 0;
   int         passedChecks = 0;
   int         startCount = 0, captureCount = 0, mulStartCount = 0, blockDoneCount = 0;
   logic [4:0] startLog[$];
   logic       validEnable = 1'b1;
   logic       mulAuto     = 1'b1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      totalChecks++;
      if (actual == expected) passedChecks++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // fft_controller model: busy for a fixed time after start, then result valid
   initial begin
      fft_in_prog    = 1'b0;
      fft_data_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (fft_start && reset_n) begin
            fft_data_valid = 1'b0;
            fft_in_prog    = 1'b1;
            repeat (FftBusyCycles) @(negedge clk);
            fft_in_prog    = 1'b0;
            fft_data_valid = validEnable;
         end
      end
   end

   initial begin
      mul_done = 1'b0;
      forever begin
         @(negedge clk);
         if (mul_start && mulAuto) begin
            repeat (MulCycles) @(negedge clk);
            mul_done = 1'b1;
            @(negedge clk);
            mul_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (fft_start) begin
            startCount++;
            startLog.push_back({fft_src_sel, fft_dst_sel, fft_forward});
         end
         if (fft_capture) captureCount++;
         if (mul_start)   mulStartCount++;
         if (block_done)  blockDoneCount++;
      end
   end

   task automatic applyStimulus(input logic kl, input logic bs, input logic ec);
      kernel_load = kl;
      block_start = bs;
      err_clear   = ec;
      @(negedge clk);
      kernel_load = 1'b0;
      block_start = 1'b0;
      err_clear   = 1'b0;
   endtask

   task automatic waitQuiet();
      int idle = 0;
      int cyc  = 0;
      while (idle < 4 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         idle = busy ? 0 : idle + 1;
      end
      if (idle < 4) checkOutput("quietWait", 0, 1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL globalTimeout: got running, expected finished");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      vecT        vecs[6];
      logic [4:0] expLog[8];
      int         s0, c0, m0, d0, s1, cnt;

      vecs[0] = '{kl: 1'b0, bs: 1'b1, ec: 1'b0, expStarts: 0, expDones: 0, expKr: 1'b0, expErr: 2'd2};
      vecs[1] = '{kl: 1'b0, bs: 1'b0, ec: 1'b1, expStarts: 0, expDones: 0, expKr: 1'b0, expErr: 2'd0};
      vecs[2] = '{kl: 1'b1, bs: 1'b0, ec: 1'b0, expStarts: 1, expDones: 0, expKr: 1'b1, expErr: 2'd0};
      vecs[3] = '{kl: 1'b0, bs: 1'b1, ec: 1'b0, expStarts: 2, expDones: 1, expKr: 1'b1, expErr: 2'd0};
      vecs[4] = '{kl: 1'b1, bs: 1'b1, ec: 1'b0, expStarts: 3, expDones: 1, expKr: 1'b1, expErr: 2'd0};
      vecs[5] = '{kl: 1'b0, bs: 1'b1, ec: 1'b0, expStarts: 2, expDones: 1, expKr: 1'b1, expErr: 2'd0};
      // {src, dst, forward}: kernel 00_00_1, signal 01_01_1, inverse 10_10_0
      expLog = '{5'b00001, 5'b01011, 5'b10100, 5'b00001, 5'b01011, 5'b10100, 5'b01011, 5'b10100};

      reset_n     = 1'b0;
      kernel_load = 1'b0;
      block_start = 1'b0;
      err_clear   = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetForward", fft_forward, 1);
      checkOutput("resetSrc", fft_src_sel, 0);
      checkOutput("resetErr", err_code, 0);
      checkOutput("resetKernelReady", kernel_ready, 0);
      checkOutput("resetStart", fft_start, 0);
      reset_n = 1'b1;
      @(negedge clk);

      startLog.delete();
      for (int i = 0; i < 6; i++) begin
         s0 = startCount;
         c0 = captureCount;
         m0 = mulStartCount;
         d0 = blockDoneCount;
         applyStimulus(vecs[i].kl, vecs[i].bs, vecs[i].ec);
         waitQuiet();
         checkOutput($sformatf("vec%0d fftStarts", i), startCount - s0, vecs[i].expStarts);
         checkOutput($sformatf("vec%0d captures", i), captureCount - c0, vecs[i].expStarts);
         checkOutput($sformatf("vec%0d mulStarts", i), mulStartCount - m0, vecs[i].expDones);
         checkOutput($sformatf("vec%0d blockDones", i), blockDoneCount - d0, vecs[i].expDones);
         checkOutput($sformatf("vec%0d kernelReady", i), kernel_ready, vecs[i].expKr);
         checkOutput($sformatf("vec%0d errCode", i), err_code, vecs[i].expErr);
      end
      checkOutput("startLogSize", startLog.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < startLog.size()) checkOutput($sformatf("startCfg%0d", i), startLog[i], expLog[i]);
      end

      // block_start accepted in IDLE must produce fft_start on the very next cycle
      d0 = blockDoneCount;
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("latStart", fft_start, 1);
      checkOutput("latSrc", fft_src_sel, 1);
      checkOutput("latDst", fft_dst_sel, 1);
      checkOutput("latForward", fft_forward, 1);
      checkOutput("latBusy", busy, 1);
      @(negedge clk);
      checkOutput("latStartOneCycle", fft_start, 0);
      checkOutput("latSrcHeld", fft_src_sel, 1);
      waitQuiet();
      checkOutput("latBlockDone", blockDoneCount - d0, 1);

      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("kLatStart", fft_start, 1);
      checkOutput("kLatReadyCleared", kernel_ready, 0);
      checkOutput("kLatSrc", fft_src_sel, 0);
      checkOutput("kLatDst", fft_dst_sel, 0);
      waitQuiet();
      checkOutput("kLatReady", kernel_ready, 1);

      // overrun: one queued block is kept, the second extra request is dropped
      s0 = startCount;
      d0 = blockDoneCount;
      applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("overrunErrImmediate", err_code, 3);
      waitQuiet();
      checkOutput("overrunStarts", startCount - s0, 4);
      checkOutput("overrunDones", blockDoneCount - d0, 2);
      checkOutput("overrunErrSticky", err_code, 3);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("overrunErrCleared", err_code, 0);

      // timeout in K_WAIT with a block queued meanwhile
      validEnable = 1'b0;
      s0 = startCount;
      d0 = blockDoneCount;
      applyStimulus(1'b1, 1'b0, 1'b0);
      cnt = 0;
      while (err_code != 2'd1 && cnt < 300) begin
         block_start = (cnt == 10);
         @(negedge clk);
         cnt++;
      end
      block_start = 1'b0;
      checkOutput("timeoutCycles", cnt, TimeoutCycles + 1);
      checkOutput("timeoutErr", err_code, 1);
      checkOutput("timeoutKernelReady", kernel_ready, 0);
      checkOutput("timeoutBusy", busy, 1);
      s1 = startCount;
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      checkOutput("errNoStrobes", startCount - s1, 0);
      checkOutput("errStillBusy", busy, 1);
      checkOutput("errStillCode", err_code, 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("errClearBusy", busy, 0);
      checkOutput("errClearCode", err_code, 0);
      validEnable = 1'b1;
      waitQuiet();
      checkOutput("timeoutPendDropStarts", startCount - s0, 1);
      checkOutput("timeoutPendDropDones", blockDoneCount - d0, 0);
      checkOutput("timeoutKernelStillNotReady", kernel_ready, 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitQuiet();
      checkOutput("reloadKernelReady", kernel_ready, 1);

      // asynchronous reset while waiting in MUL
      mulAuto = 1'b0;
      d0 = blockDoneCount;
      applyStimulus(1'b0, 1'b1, 1'b0);
      cnt = 0;
      while (!mul_start && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("mulStartSeen", mul_start, 1);
      repeat (2) @(negedge clk);
      checkOutput("inMulSrc", fft_src_sel, 1);
      reset_n = 1'b0;
      #1;
      checkOutput("rstMidBusy", busy, 0);
      checkOutput("rstMidKernelReady", kernel_ready, 0);
      checkOutput("rstMidForward", fft_forward, 1);
      checkOutput("rstMidSrc", fft_src_sel, 0);
      checkOutput("rstMidDst", fft_dst_sel, 0);
      checkOutput("rstMidErr", err_code, 0);
      checkOutput("rstMidMulStart", mul_start, 0);
      @(negedge clk);
      reset_n = 1'b1;
      mulAuto = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("rstNoBlockDone", blockDoneCount - d0, 0);
      checkOutput("rstStaysIdle", busy, 0);
      checkOutput("rstKernelLost", kernel_ready, 0);

      $display("%0d/%0d checks passed", passedChecks, totalChecks);
      $finish;
   end

endmodule
